axi_slave_mem: RTL

Synthesizable AXI4 full slave with an internal word-addressed memory. It is the responder end for the AXI master bus-functional model and lets master-side testbenches run write/read-and-check sequences against real slave handshakes. The write path (AW/W/B) and read path (AR/R) are independent state machines sharing one memory array. Data bus is 32 bits wide and IDs are 4 bits wide.

---
 rtl/axi_slave_mem.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_slave_mem.sv
// AXI4 slave over a word-addressed memory: read data one cycle after AR, write response one cycle after the last W beat.
// Backpressure: R and B outputs hold while rready/bready are low; AW/AR are refused while a burst of that direction is open.
module axi_slave_mem #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          DEPTH_LOG2 = 8
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  awid,
    input  logic [31:0] awadr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wrdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);
    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [31:0] LIMIT = 32'd4 << DEPTH_LOG2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    logic [31:0] mem [DEPTH];

    function automatic logic [31:0] beat_step(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst);
        return (burst == 2'b01) ? addr + (32'd1 << size) : addr;
    endfunction

    function automatic logic beat_bad(input logic [31:0] off, input logic [2:0] size,
                                      input logic [1:0] burst);
        return burst[1] || (size > 3'd2) || (off >= LIMIT);
    endfunction

    // ---------------- write path ----------------
    w_state_t    w_state, w_next;
    logic [3:0]  w_id;
    logic [31:0] w_addr, w_off;
    logic [7:0]  w_len, w_cnt;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic        w_err, w_bad, w_mis;
    logic        aw_hs, w_hs, b_hs;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;
    assign w_off = w_addr - BASE_ADDR;
    assign w_bad = beat_bad(w_off, w_size, w_burst);
    assign w_mis = wlast != (w_cnt == w_len);

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && wlast) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they are all low during reset.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
        end else begin
            w_state <= w_next;
            awready <= (w_next == W_IDLE);
            wready  <= (w_next == W_DATA);
            bvalid  <= (w_next == W_RESP);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            bid     <= '0;
            bresp   <= '0;
        end else begin
            if (aw_hs) begin
                w_id    <= awid;
                w_addr  <= awadr;
                w_len   <= awlen;
                w_size  <= awsize;
                w_burst <= awburst;
                w_cnt   <= '0;
                w_err   <= 1'b0;
            end
            if (w_hs) begin
                w_addr <= beat_step(w_addr, w_size, w_burst);
                w_cnt  <= w_cnt + 8'd1;
                w_err  <= w_err | w_bad | w_mis;
                if (wlast) begin
                    bid   <= w_id;
                    bresp <= (w_err || w_bad || w_mis) ? 2'b10 : 2'b00;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && !w_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[w_off[DEPTH_LOG2+1:2]][8*i +: 8] <= wrdata[8*i +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    r_state_t    r_state, r_next;
    logic [31:0] r_addr;
    logic [7:0]  r_len, r_cnt;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic        ar_hs, r_hs;
    logic [31:0] ld_addr, ld_off, ld_data;
    logic [2:0]  ld_size;
    logic [1:0]  ld_burst;
    logic        ld_bad;

    assign ar_hs    = arvalid && arready;
    assign r_hs     = rvalid && rready;
    // Address of the beat being loaded: the AR address on accept, else the step after the current beat.
    assign ld_addr  = ar_hs ? araddr  : beat_step(r_addr, r_size, r_burst);
    assign ld_size  = ar_hs ? arsize  : r_size;
    assign ld_burst = ar_hs ? arburst : r_burst;
    assign ld_off   = ld_addr - BASE_ADDR;
    assign ld_bad   = beat_bad(ld_off, ld_size, ld_burst);
    assign ld_data  = mem[ld_off[DEPTH_LOG2+1:2]];

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
        end else begin
            r_state <= r_next;
            arready <= (r_next == R_IDLE);
            rvalid  <= (r_next == R_DATA);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= '0;
            rlast   <= 1'b0;
        end else if (ar_hs) begin
            rid     <= arid;
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_cnt   <= '0;
            rlast   <= (arlen == 8'd0);
            rdata   <= ld_bad ? 32'd0 : ld_data;
            rresp   <= ld_bad ? 2'b10 : 2'b00;
        end else if (r_hs) begin
            if (rlast) begin
                rlast <= 1'b0;
            end else begin
                r_addr <= ld_addr;
                r_cnt  <= r_cnt + 8'd1;
                rlast  <= ((r_cnt + 8'd1) == r_len);
                rdata  <= ld_bad ? 32'd0 : ld_data;
                rresp  <= ld_bad ? 2'b10 : 2'b00;
            end
        end
    end

    logic unused_sink;
    assign unused_sink = ^{awlock, awcache, awprot, arlock, arcache, arprot, wid,
                           w_off[1:0], ld_off[1:0]};
endmodule
